bitwise_seq: RTL

//   Parametrised, handshaked bitwise/rotate unit for the ALU. Performs AND/OR/XOR
//   in one cycle and rotate-through-carry by a variable count, one bit per cycle.
//   An optional output inversion applies to both q and cout. Zero and parity flags
//   are registered with the result. Sits between the operand latch and the

---
 rtl/bitwise_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bitwise_seq.sv
// Handshaked bitwise / rotate-through-carry unit: AND/OR/XOR in one cycle,
// rotate on the {carry, result} ring one bit per cycle, optional output inversion.
module bitwise_seq #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] q,
   output logic             cout,
   output logic             zero,
   output logic             parity
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] r, r_n;
   logic             c, c_n;
   logic [SHW-1:0]   cnt, cnt_n;
   logic             dir, dir_n;
   logic             inv, inv_n;
   logic             flag_ld;
   logic             accept;
   logic [WIDTH-1:0] logic_res;
   logic [WIDTH-1:0] step_r;
   logic             step_c;
   logic [SHW-1:0]   n;

   assign n         = b[SHW-1:0];
   assign out_valid = (state == DONE);
   assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
   assign accept    = in_valid & in_ready;
   assign q         = r;
   assign cout      = c;

   // One step around the (WIDTH+1)-bit ring formed by carry and result.
   assign step_r = dir ? {c, r[WIDTH-1:1]} : {r[WIDTH-2:0], c};
   assign step_c = dir ? r[0] : r[WIDTH-1];

   always_comb begin
      logic_res = a ^ b;
      case (op[1:0])
         2'b00:   logic_res = a & b;
         2'b01:   logic_res = a | b;
         default: logic_res = a ^ b;
      endcase
   end

   always_comb begin
      state_n = state;
      r_n     = r;
      c_n     = c;
      cnt_n   = cnt;
      dir_n   = dir;
      inv_n   = inv;
      flag_ld = 1'b0;

      case (state)
         SHIFT: begin
            cnt_n = cnt - 1'b1;
            if (cnt == SHW'(1)) begin
               r_n     = step_r ^ {WIDTH{inv}};
               c_n     = step_c ^ inv;
               flag_ld = 1'b1;
               state_n = DONE;
            end else begin
               r_n = step_r;
               c_n = step_c;
            end
         end
         DONE: begin
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      // An accept in DONE (same cycle as the handshake) behaves exactly like one from IDLE.
      if (accept) begin
         inv_n = op[2];
         dir_n = op[3];
         if (op[1:0] != 2'b11) begin
            r_n     = logic_res ^ {WIDTH{op[2]}};
            c_n     = cin ^ op[2];
            flag_ld = 1'b1;
            state_n = DONE;
         end else if (n == '0) begin
            r_n     = a ^ {WIDTH{op[2]}};
            c_n     = cin ^ op[2];
            flag_ld = 1'b1;
            state_n = DONE;
         end else begin
            r_n     = a;
            c_n     = cin;
            cnt_n   = n;
            state_n = SHIFT;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         r      <= '0;
         c      <= 1'b0;
         cnt    <= '0;
         dir    <= 1'b0;
         inv    <= 1'b0;
         zero   <= 1'b0;
         parity <= 1'b0;
      end else begin
         state <= state_n;
         r     <= r_n;
         c     <= c_n;
         cnt   <= cnt_n;
         dir   <= dir_n;
         inv   <= inv_n;
         if (flag_ld) begin
            zero   <= (r_n == '0);
            parity <= ^r_n;
         end
      end
   end

endmodule
